// File: rtl/otfc_pkg.sv
// Shared types and signed-digit codes for the on-the-fly converter receiver.
package otfc_pkg;
    typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} state_t;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_BAD  = 2'b11;
endpackage

// File: rtl/otfc_rx_sd_dec.sv
// Signed-digit decoder: splits the two-rail {z_p,z_n} code into one-hot flags.
module sd_dec
    import otfc_pkg::*;
(
    input  logic z_p_i,
    input  logic z_n_i,
    output logic pos_o,
    output logic neg_o,
    output logic bad_o
);
    logic [1:0] code;

    assign code  = {z_p_i, z_n_i};
    assign pos_o = (code == SD_POS);
    assign neg_o = (code == SD_NEG);
    assign bad_o = (code == SD_BAD);
endmodule

// File: rtl/otfc_rx.sv
// MSDF signed-digit stream to two's-complement on-the-fly converter.
// Define OTFC_ERR_EN to build the sticky illegal-code (err) flag.
module otfc_rx
    import otfc_pkg::*;
#(
    parameter int N     = 8,
    parameter int DELTA = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z_p,
    input  logic       z_n,
    output logic [N:0] q,
    output logic       valid,
    output logic       busy,
    output logic       err
);
    localparam int CMAX = (N > DELTA) ? N : DELTA;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SKIP_LAST = CW'((DELTA > 0) ? DELTA - 1 : 0);
    localparam logic [CW-1:0] CONV_LAST = CW'(N - 1);
    localparam state_t        FIRST_ST  = (DELTA == 0) ? CONV : SKIP;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    qr_q, qr_d;
    logic [N:0]    qm_q, qm_d;
    logic [N:0]    q_q, q_d;
    logic          valid_q, valid_d;
    logic          start_acc;
    logic          pos, neg, bad;

    sd_dec u_dec (
        .z_p_i (z_p),
        .z_n_i (z_n),
        .pos_o (pos),
        .neg_o (neg),
        .bad_o (bad)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qr_d      = qr_q;
        qm_d      = qm_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: start_acc = start;
            SKIP: begin
                if (cnt_q == SKIP_LAST) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CONV: begin
                // Q tracks the value, QM tracks value minus one ulp, so a -1
                // digit never needs a borrow chain.
                if (pos) begin
                    qr_d = {qr_q[N-1:0], 1'b1};
                    qm_d = {qr_q[N-1:0], 1'b0};
                end else if (neg) begin
                    qr_d = {qm_q[N-1:0], 1'b1};
                    qm_d = {qm_q[N-1:0], 1'b0};
                end else begin
                    qr_d = {qr_q[N-1:0], 1'b0};
                    qm_d = {qm_q[N-1:0], 1'b1};
                end
                if (cnt_q == CONV_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    q_d     = qr_d;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                start_acc = start;
            end
            default: state_d = IDLE;
        endcase
        if (start_acc) begin
            state_d = FIRST_ST;
            cnt_d   = '0;
            qr_d    = '0;
            qm_d    = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qr_q    <= '0;
            qm_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qr_q    <= qr_d;
            qm_q    <= qm_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign busy  = (state_q == SKIP) || (state_q == CONV);

`ifdef OTFC_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (start_acc)
            err_q <= 1'b0;
        else if (state_q == CONV && bad)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_bad;

    assign unused_bad = bad;
    assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_otfc_rx.sv
// Directed table-driven bench for otfc_rx at N=8, DELTA=6.
module tb_otfc_rx;
    localparam int N     = 8;
    localparam int DELTA = 6;
    localparam int LAT   = 1 + DELTA + N;
    localparam logic [1:0] P = 2'b10, M = 2'b01, Z = 2'b00, B = 2'b11;
`ifdef OTFC_ERR_EN
    localparam logic EXP_BAD_ERR = 1'b1;
`else
    localparam logic EXP_BAD_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, z_p, z_n;
    logic [N:0] q;
    logic       valid, busy, err;

    int checks   = 0;
    int failures = 0;

    otfc_rx #(.N(N), .DELTA(DELTA)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .z_p   (z_p),
        .z_n   (z_n),
        .q     (q),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                name;
        logic [N-1:0][1:0]    codes;
        logic                 b2b;
        logic [N:0]           exp_q;
        logic                 exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a word in the current cycle, streams digits, and returns while
    // sitting in the DONE cycle (valid high) so a back-to-back start can follow.
    task automatic run_word(input string name, input logic [N-1:0][1:0] codes,
                            input logic [N:0] prev_q, output int lat,
                            output logic [N:0] qv, output logic ev);
        logic held;
        held = 1'b1;
        lat  = -1;
        qv   = '0;
        ev   = 1'b0;
        start = 1'b1;
        {z_p, z_n} = B;
        tick();
        start = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (k == 1) chk({name, " busy_skip"}, 32'(busy), 32'd1);
            if (valid) begin
                lat = k;
                qv  = q;
                ev  = err;
                chk({name, " busy_done"}, 32'(busy), 32'd0);
                break;
            end
            if (q !== prev_q) held = 1'b0;
            if (k <= DELTA)          {z_p, z_n} = B;
            else if (k <= DELTA + N) {z_p, z_n} = codes[N-1-(k-DELTA-1)];
            else                     {z_p, z_n} = Z;
            tick();
        end
        chk({name, " q_hold"}, 32'(held), 32'd1);
    endtask

    initial begin
        int         lat;
        logic [N:0] qv;
        logic       ev;
        logic [N:0] prev_q;
        int         vcount;

        vecs[0] = '{"pos_half", {P,Z,Z,Z,Z,Z,Z,Z}, 1'b0, 9'h080, 1'b0};
        vecs[1] = '{"neg_half", {M,Z,Z,Z,Z,Z,Z,Z}, 1'b0, 9'h180, 1'b0};
        vecs[2] = '{"one_ulp",  {P,M,M,M,M,M,M,M}, 1'b0, 9'h001, 1'b0};
        vecs[3] = '{"all_neg",  {M,M,M,M,M,M,M,M}, 1'b0, 9'h101, 1'b0};
        vecs[4] = '{"b2b_zero", {Z,Z,Z,Z,Z,Z,Z,Z}, 1'b1, 9'h000, 1'b0};
        vecs[5] = '{"bad_d3",   {P,P,B,Z,Z,Z,Z,Z}, 1'b0, 9'h0C0, EXP_BAD_ERR};
        vecs[6] = '{"mixed",    {Z,P,Z,M,P,Z,Z,M}, 1'b0, 9'h037, 1'b0};

        rst = 1'b1; start = 1'b0; {z_p, z_n} = Z;
        tick(); tick();
        chk("reset q",     32'(q),     32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset err",   32'(err),   32'd0);
        rst = 1'b0;
        tick();

        prev_q = '0;
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].b2b) begin
                tick();
                chk({vecs[i].name, " valid_idle"}, 32'(valid), 32'd0);
            end
            run_word(vecs[i].name, vecs[i].codes, prev_q, lat, qv, ev);
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(LAT));
            chk({vecs[i].name, " q"},       32'(qv),  32'(vecs[i].exp_q));
            chk({vecs[i].name, " err"},     32'(ev),  32'(vecs[i].exp_err));
            prev_q = vecs[i].exp_q;
        end

        // Abort a word with rst in its 4th CONV cycle.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        {z_p, z_n} = Z;
        repeat (DELTA) tick();
        {z_p, z_n} = P;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("abort q",     32'(q),     32'd0);
        chk("abort valid", 32'(valid), 32'd0);
        chk("abort busy",  32'(busy),  32'd0);
        chk("abort err",   32'(err),   32'd0);
        tick();
        rst = 1'b0;
        {z_p, z_n} = Z;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid) vcount++;
            tick();
        end
        chk("abort no_valid", 32'(vcount), 32'd0);

        run_word("after_abort", {P,Z,Z,Z,Z,Z,Z,Z}, 9'h000, lat, qv, ev);
        chk("after_abort latency", 32'(lat), 32'(LAT));
        chk("after_abort q",       32'(qv),  32'h080);
        tick();
        chk("after_abort hold", 32'(q), 32'h080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/otfc_rx.md
OTFC_RX -- requirements
Module: otfc_rx

Interface
REQ-001 SHALL have parameter N, default 8: number of signed digits per word.
REQ-002 SHALL have parameter DELTA, default 6: online delay, i.e. cycles between start and the first digit (three OA levels at 2 each).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins one conversion.
REQ-006 SHALL have port z_p, input, 1 bit: positive rail of the MSDF signed-digit stream.
REQ-007 SHALL have port z_n, input, 1 bit: negative rail of the same stream.
REQ-008 SHALL have port q, output, N+1 bits: two's-complement result, 1 sign bit plus N fraction bits.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when q holds a new result.
REQ-010 SHALL have port busy, output, 1 bit: high in SKIP and CONV.
REQ-011 SHALL have port err, output, 1 bit: sticky flag for an illegal digit code.

Function
REQ-012 SHALL decode each digit from {z_p,z_n} as: 10 = +1, 01 = -1, 00 = 0, 11 = 0 (illegal code).
REQ-013 SHALL treat the word value as the sum of d_i*2^-i for i = 1..N, with the most significant digit first.
REQ-014 SHALL implement a four-state FSM: IDLE, SKIP, CONV, DONE.
REQ-015 SHALL move IDLE->SKIP when start=1, clearing the digit counter, setting Q=0, setting QM = all ones (-2^-N... i.e. -1 ulp form), and clearing err.
REQ-016 SHALL, in SKIP, ignore z_p/z_n for DELTA cycles and then move to CONV; when DELTA=0, IDLE SHALL go directly to CONV.
REQ-017 SHALL, in CONV, sample one digit per cycle for exactly N cycles and then move to DONE.
REQ-018 SHALL update Q, for digit d, as: d=+1 -> {Q,1}; d=0 -> {Q,0}; d=-1 -> {QM,1}.
REQ-019 SHALL update QM, for digit d, as: d=+1 -> {Q,0}; d=0 -> {QM,1}; d=-1 -> {QM,0}.
REQ-020 SHALL keep both Q and QM N+1 bits wide, with each shift discarding the bit above the sign.
REQ-021 SHALL, in DONE, drive q=Q and valid=1 for one cycle, then return to IDLE.
REQ-022 SHALL, given start asserted in cycle t, sample the first digit in cycle t+1+DELTA and assert valid in cycle t+1+DELTA+N.
REQ-023 SHALL ignore start in SKIP and CONV.
REQ-024 SHALL accept start in DONE and go to SKIP (or CONV if DELTA=0), giving back-to-back words with no gap cycle.
REQ-025 SHALL hold q between valid pulses and update it only in DONE.

Reset
REQ-026 SHALL, on rst=1 in any state, asynchronously force state=IDLE, q=0, Q=0, QM=0, counter=0, valid=0, busy=0, err=0.
REQ-027 SHALL, after reset mid-conversion, produce no valid pulse for the aborted word.

Configuration
REQ-028 SHALL, with OTFC_ERR_EN defined, set err to 1 when code 11 is sampled in CONV and hold it until the next accepted start or rst.
REQ-029 SHALL, without OTFC_ERR_EN, tie err to 0 and omit its logic; code 11 still decodes as 0.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, SKIP, CONV, DONE) and the digit-code constants (SD_POS=10, SD_NEG=01, SD_ZERO=00, SD_BAD=11) in package otfc_pkg.
REQ-031 SHALL instantiate one sub-module, sd_dec, which maps {z_p,z_n} to the flags pos, neg and bad.
REQ-032 SHALL size the digit counter to clog2(max(N,DELTA)+1) bits.

Verification (N=8, DELTA=6)
REQ-033 SHALL test digits +1,0,0,0,0,0,0,0 -> q=9'h080 (0.5), valid in cycle t+15.
REQ-034 SHALL test digits -1,0,0,0,0,0,0,0 -> q=9'h180 (-0.5).
REQ-035 SHALL test digits +1,-1,-1,-1,-1,-1,-1,-1 -> q=9'h001 (1/256).
REQ-036 SHALL test all digits -1 -> q=9'h101 (-255/256); immediately follow with start in DONE and all digits 0 -> q=9'h000, with the two valid pulses 15 cycles apart.
REQ-037 SHALL test rst=1 pulsed during the 4th CONV cycle -> all outputs 0 and no valid pulse; a new start then converts correctly.
REQ-038 SHALL test code 11 injected at digit 3 -> err=1 with OTFC_ERR_EN defined and err=0 without; in both builds q equals the result with that digit taken as 0.
